// File: rtl/krnl_vadd_rtl_wr_burst_buffer.sv
// krnl_vadd_rtl_wr_burst_buffer
// Buffers the adder's result stream in a FIFO and hands it to the write
// master in burst-sized groups. Each group is announced by a burst_req pulse.
// A programmed transfer length is counted, and ctrl_done pulses once the
// final word has been emitted.
module krnl_vadd_rtl_wr_burst_buffer #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_LEN_WIDTH  = 32,
   parameter int C_BURST_LEN  = 16,
   parameter int C_FIFO_DEPTH = 64
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic                           ctrl_start,
   input  logic [C_LEN_WIDTH-1:0]         ctrl_xfer_len,
   output logic                           ctrl_done,
   input  logic                           s_tvalid,
   output logic                           s_tready,
   input  logic [C_DATA_WIDTH-1:0]        s_tdata,
   output logic                           burst_req,
   output logic [$clog2(C_BURST_LEN):0]   burst_beats,
   output logic                           m_tvalid,
   input  logic                           m_tready,
   output logic [C_DATA_WIDTH-1:0]        m_tdata,
   output logic                           m_tlast
);

   localparam int BW  = $clog2(C_BURST_LEN) + 1;
   localparam int AW  = $clog2(C_FIFO_DEPTH);
   localparam int LVW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [C_LEN_WIDTH-1:0]  in_rem, out_rem;
   logic [LVW-1:0]          level;
   logic [BW-1:0]           beat_cnt;
   logic                    burst_open;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];

   logic                    push, pop, open_burst;
   logic [BW-1:0]           need;

   // Handshakes, burst sizing and the burst-open decision, all from registered state
   always_comb begin
      s_tready   = (state == S_RUN) && (level < LVW'(C_FIFO_DEPTH)) && (in_rem != '0);
      push       = s_tvalid && s_tready;
      pop        = burst_open && m_tready;
      need       = (out_rem >= C_LEN_WIDTH'(C_BURST_LEN)) ? BW'(C_BURST_LEN) : out_rem[BW-1:0];
      open_burst = (state == S_RUN) && !burst_open && (need != '0) && (level >= LVW'(need));
      m_tvalid   = burst_open;
      m_tlast    = burst_open && (beat_cnt == BW'(1));
      m_tdata    = mem[rd_ptr];
   end

   // Next-state logic: leave RUN on the pop that drains out_rem to zero
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (ctrl_start) state_nxt = (ctrl_xfer_len == '0) ? S_DONE : S_RUN;
         S_RUN:  if (pop && (out_rem == C_LEN_WIDTH'(1))) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge aclk) begin
      if (areset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Counters, FIFO pointers, burst tracking and registered pulses
   always_ff @(posedge aclk) begin
      if (areset) begin
         in_rem      <= '0;
         out_rem     <= '0;
         level       <= '0;
         beat_cnt    <= '0;
         burst_open  <= 1'b0;
         burst_req   <= 1'b0;
         burst_beats <= '0;
         ctrl_done   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         burst_req <= open_burst;
         ctrl_done <= (state == S_DONE);

         if ((state == S_IDLE) && ctrl_start) begin
            in_rem  <= ctrl_xfer_len;
            out_rem <= ctrl_xfer_len;
         end else begin
            if (push) in_rem  <= in_rem - C_LEN_WIDTH'(1);
            if (pop)  out_rem <= out_rem - C_LEN_WIDTH'(1);
         end

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);

         if (push && !pop)      level <= level + LVW'(1);
         else if (pop && !push) level <= level - LVW'(1);

         // A burst can only open while none is open, which guarantees the
         // one-cycle m_tvalid gap after the previous burst's last beat.
         if (open_burst) begin
            burst_open  <= 1'b1;
            burst_beats <= need;
            beat_cnt    <= need;
         end else if (pop) begin
            beat_cnt <= beat_cnt - BW'(1);
            if (beat_cnt == BW'(1)) burst_open <= 1'b0;
         end
      end
   end

   // FIFO storage
   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr] <= s_tdata;
   end

endmodule

// File: tb/tb_krnl_vadd_rtl_wr_burst_buffer.sv
// Scoreboard bench for krnl_vadd_rtl_wr_burst_buffer: the driver queues the
// expected output words and burst sizes, and a negedge monitor checks them.
module tb_krnl_vadd_rtl_wr_burst_buffer;

   localparam int DW = 32;
   localparam int LW = 32;
   localparam int BL = 16;
   localparam int FD = 64;

   logic                  aclk = 1'b0;
   logic                  areset, ctrl_start, ctrl_done;
   logic [LW-1:0]         ctrl_xfer_len;
   logic                  s_tvalid, s_tready, burst_req, m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]         s_tdata, m_tdata;
   logic [$clog2(BL):0]   burst_beats;

   krnl_vadd_rtl_wr_burst_buffer #(
      .C_DATA_WIDTH(DW), .C_LEN_WIDTH(LW), .C_BURST_LEN(BL), .C_FIFO_DEPTH(FD)
   ) dut (
      .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_xfer_len(ctrl_xfer_len),
      .ctrl_done(ctrl_done), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .burst_req(burst_req), .burst_beats(burst_beats), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
   );

   always #5 aclk = ~aclk;

   int          n_total = 0, n_pass = 0, n_fail = 0;
   logic [32:0] exp_q[$];
   int          exp_beats[$];
   int          model_level = 0, n_pop = 0, burst_sum = 0, done_cnt = 0, done0 = 0;
   int          mode = 1;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;

   function automatic void chk(string name, longint act, longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endfunction

   function automatic void timeout(string name);
      n_total++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endfunction

   // Monitor: level model, invariants, stall stability, burst and data scoreboard
   always @(negedge aclk) begin
      if (areset) begin
         model_level = 0;
         prev_stall  = 1'b0;
      end else begin
         logic [32:0] e;
         chk("level_model", int'(dut.level), model_level);
         if (model_level > FD) chk("level_bound", model_level, FD);
         if (m_tvalid) chk("valid_nonempty", int'(dut.level != 0), 1);
         if (prev_stall) begin
            chk("stall_valid", m_tvalid, 1);
            chk("stall_data", m_tdata, prev_data);
            chk("stall_last", m_tlast, prev_last);
         end
         if (burst_req) begin
            if (exp_beats.size() == 0) chk("burst_unexpected", burst_beats, 0);
            else chk("burst_beats", burst_beats, exp_beats.pop_front());
            chk("burst_words_ready", int'(model_level >= int'(burst_beats)), 1);
            burst_sum += int'(burst_beats);
         end
         if (ctrl_done) done_cnt++;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) chk("word_unexpected", m_tdata, -1);
            else begin
               e = exp_q.pop_front();
               chk("m_tdata", m_tdata, e[31:0]);
               chk("m_tlast", m_tlast, e[32]);
            end
            n_pop++;
         end
         model_level += int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   // Write-master ready pattern: 0 = always ready, 1 = stalled, 2 = random
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         case (mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic step();
      @(posedge aclk); #1;
   endtask

   task automatic start_xfer(input int len);
      int rem = len;
      while (rem > 0) begin
         exp_beats.push_back(rem > BL ? BL : rem);
         rem -= (rem > BL ? BL : rem);
      end
      n_pop = 0; burst_sum = 0; done0 = done_cnt;
      ctrl_start = 1'b1; ctrl_xfer_len = LW'(len);
      step();
      ctrl_start = 1'b0;
   endtask

   task automatic send_words(input int first, input int n, input int len,
                             input logic [31:0] base, input bit gaps);
      for (int i = first; i < first + n; i++) begin
         int waited = 0;
         bit last;
         if (gaps) repeat ($urandom_range(0, 2)) begin s_tvalid = 1'b0; step(); end
         s_tvalid = 1'b1; s_tdata = base + 32'(i);
         last = (((i + 1) % BL) == 0) || ((i + 1) == len);
         forever begin
            @(negedge aclk);
            if (s_tready) break;
            if (++waited > 1000) begin timeout("s_accept"); s_tvalid = 1'b0; return; end
         end
         exp_q.push_back({last, base + 32'(i)});
         step();
      end
      s_tvalid = 1'b0;
   endtask

   task automatic wait_done(input int len);
      int waited = 0;
      while (done_cnt == done0) begin
         @(negedge aclk);
         if (++waited > 3000) begin timeout("ctrl_done"); break; end
      end
      chk("words_out", n_pop, len);
      chk("burst_sum", burst_sum, len);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("exp_beats_empty", exp_beats.size(), 0);
      repeat (3) @(negedge aclk);
      chk("done_once", done_cnt, done0 + 1);
      step();
   endtask

   initial begin
      int d0;
      areset = 1'b1; ctrl_start = 1'b0; ctrl_xfer_len = '0; s_tvalid = 1'b0; s_tdata = '0;
      repeat (3) step();
      areset = 1'b0;
      @(negedge aclk);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_burst_req", burst_req, 0);
      chk("rst_ctrl_done", ctrl_done, 0);
      chk("rst_burst_beats", burst_beats, 0);
      chk("rst_level", int'(dut.level), 0);
      step();

      // Zero-length transfer: done two cycles after the start pulse
      start_xfer(0);
      @(negedge aclk);
      chk("len0_done_early", ctrl_done, 0);
      chk("len0_s_tready", s_tready, 0);
      @(negedge aclk);
      chk("len0_done", ctrl_done, 1);
      @(negedge aclk);
      chk("len0_done_clear", ctrl_done, 0);
      chk("len0_idle_ready", s_tready, 0);
      chk("len0_no_burst", burst_sum, 0);
      step();

      // Two full bursts, always ready
      mode = 0;
      start_xfer(32);
      send_words(0, 32, 32, 32'hA000_0000, 1'b0);
      wait_done(32);

      // Full burst then a 4-beat tail
      start_xfer(20);
      send_words(0, 20, 20, 32'hB000_0000, 1'b0);
      wait_done(20);

      // Write master stalled: FIFO fills and backpressures the adder
      mode = 1;
      start_xfer(100);
      fork
         send_words(0, 100, 100, 32'hC000_0000, 1'b0);
         begin
            repeat (200) step();
            chk("full_level", int'(dut.level), FD);
            chk("full_s_tready", s_tready, 0);
            mode = 0;
         end
      join
      wait_done(100);

      // Random input gaps and write-master stalls
      mode = 2;
      start_xfer(37);
      send_words(0, 37, 37, 32'hD000_0000, 1'b1);
      wait_done(37);

      // A start pulse during RUN must not disturb the transfer
      mode = 0;
      start_xfer(32);
      send_words(0, 10, 32, 32'hE000_0000, 1'b0);
      ctrl_start = 1'b1; ctrl_xfer_len = LW'(5);
      step();
      ctrl_start = 1'b0;
      send_words(10, 22, 32, 32'hE000_0000, 1'b0);
      wait_done(32);

      // Reset in the middle of a burst
      mode = 1;
      start_xfer(32);
      send_words(0, 20, 32, 32'hF000_0000, 1'b0);
      mode = 0;
      repeat (3) step();
      d0 = done_cnt;
      areset = 1'b1;
      step();
      areset = 1'b0;
      exp_q.delete();
      exp_beats.delete();
      @(negedge aclk);
      chk("mid_rst_s_tready", s_tready, 0);
      chk("mid_rst_m_tvalid", m_tvalid, 0);
      chk("mid_rst_m_tlast", m_tlast, 0);
      chk("mid_rst_burst_req", burst_req, 0);
      chk("mid_rst_burst_beats", burst_beats, 0);
      chk("mid_rst_ctrl_done", ctrl_done, 0);
      chk("mid_rst_level", int'(dut.level), 0);
      repeat (5) @(negedge aclk);
      chk("mid_rst_no_done", done_cnt, d0);
      step();

      start_xfer(16);
      send_words(0, 16, 16, 32'h1234_0000, 1'b0);
      wait_done(16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
